// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array tile sequencer.
// States, array geometry, and the row pack/unpack between a 128-bit C row and its four 32-bit lanes.
package sa_pkg;

   localparam int unsigned ROWS      = 4;
   localparam int unsigned LANES     = 4;
   localparam int unsigned LANE_BITS = 32;
   localparam int unsigned ROW_BITS  = LANES * LANE_BITS;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StFetch = 3'd1,
      StKick  = 3'd2,
      StWait  = 3'd3,
      StAccum = 3'd4,
      StDrain = 3'd5,
      StDone  = 3'd6
   } sa_state_e;

   typedef logic [LANES-1:0][LANE_BITS-1:0] lanes_t;

   // Lane 0 lives in the most significant 32 bits of a packed row.
   function automatic lanes_t row_unpack(input logic [ROW_BITS-1:0] row);
      lanes_t l;
      for (int j = 0; j < LANES; j++) begin
         l[j] = row[(LANES-1-j)*LANE_BITS +: LANE_BITS];
      end
      return l;
   endfunction

   function automatic logic [ROW_BITS-1:0] row_pack(input lanes_t l);
      logic [ROW_BITS-1:0] row;
      for (int j = 0; j < LANES; j++) begin
         row[(LANES-1-j)*LANE_BITS +: LANE_BITS] = l[j];
      end
      return row;
   endfunction

endpackage

// File: rtl/sa_acc_bank.sv
// 4x4 bank of 32-bit partial-sum accumulators.
// load_i overwrites with the captured C tile, add_i adds it (wrapping); one row readable at a time.
module sa_acc_bank
   import sa_pkg::*;
(
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           load_i,
   input  logic                           add_i,
   input  logic [ROWS-1:0][ROW_BITS-1:0]  c_i,
   input  logic [1:0]                     rd_row_i,
   output logic [ROW_BITS-1:0]            rd_data_o
);

   lanes_t [ROWS-1:0] acc_q, acc_d;
   lanes_t [ROWS-1:0] c_lanes;

   // Split each incoming C row into its lanes.
   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         c_lanes[r] = row_unpack(c_i[r]);
      end
   end

   // Next partial sums: load on the first K-tile, wrap-around add afterwards.
   always_comb begin
      acc_d = acc_q;
      for (int r = 0; r < ROWS; r++) begin
         for (int j = 0; j < LANES; j++) begin
            if (load_i) begin
               acc_d[r][j] = c_lanes[r][j];
            end else if (add_i) begin
               acc_d[r][j] = acc_q[r][j] + c_lanes[r][j];
            end
         end
      end
   end

   // Accumulator storage.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign rd_data_o = row_pack(acc_q[rd_row_i]);

endmodule

// File: rtl/sa_tile_sequencer.sv
// K-tiled matmul sequencer for a 4x4 int8 systolic-array core.
// Per tile: fetch A/B rows, restart core, capture C on done rise, accumulate; then drain C rows.
// Optional macro SA_WATCHDOG_EN bounds the WAIT state to WDOG_CYCLES cycles.
module sa_tile_sequencer
   import sa_pkg::*;
#(
   parameter int unsigned ADDR_BITS  = 16,
   parameter int unsigned DATA_BITS  = 32,
   parameter int unsigned DATAC_BITS = 128,
   parameter int unsigned KT_BITS    = 4
`ifdef SA_WATCHDOG_EN
   ,
   parameter int unsigned WDOG_CYCLES = 64
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [KT_BITS-1:0]    k_tiles,
   input  logic [ADDR_BITS-1:0]  base_addr,
   output logic                  rd_en,
   output logic [ADDR_BITS-1:0]  rd_addr,
   input  logic [DATA_BITS-1:0]  rd_data,
   output logic                  sa_rst_n,
   output logic                  sa_busy,
   input  logic                  sa_done,
   output logic [DATA_BITS-1:0]  sa_a0,
   output logic [DATA_BITS-1:0]  sa_a1,
   output logic [DATA_BITS-1:0]  sa_a2,
   output logic [DATA_BITS-1:0]  sa_a3,
   output logic [DATA_BITS-1:0]  sa_b0,
   output logic [DATA_BITS-1:0]  sa_b1,
   output logic [DATA_BITS-1:0]  sa_b2,
   output logic [DATA_BITS-1:0]  sa_b3,
   input  logic [DATAC_BITS-1:0] sa_c0,
   input  logic [DATAC_BITS-1:0] sa_c1,
   input  logic [DATAC_BITS-1:0] sa_c2,
   input  logic [DATAC_BITS-1:0] sa_c3,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [1:0]            out_row,
   output logic [DATAC_BITS-1:0] out_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   sa_state_e                     state_q, state_d;
   logic [KT_BITS-1:0]            k_q, k_d;
   logic [KT_BITS-1:0]            kt_q, kt_d;
   logic [ADDR_BITS-1:0]          base_q, base_d;
   logic [3:0]                    fetch_cnt_q, fetch_cnt_d;
   logic [1:0]                    row_q, row_d;
   logic                          err_q, err_d;
   logic                          sa_done_q;
   logic [7:0][DATA_BITS-1:0]     ab_q, ab_d;
   logic [ROWS-1:0][DATAC_BITS-1:0] c_q, c_d;
   logic                          acc_load, acc_add;
   logic [ROW_BITS-1:0]           acc_rd;
   logic [2:0]                    wr_idx;
   logic                          done_rise;

`ifdef SA_WATCHDOG_EN
   localparam int unsigned WdW = $clog2(WDOG_CYCLES + 1);
   logic [WdW-1:0]                wdog_q, wdog_d;
`endif

   // Row i of a fetch lands one cycle after its read, i.e. at count i+1.
   assign wr_idx    = 3'(fetch_cnt_q - 4'd1);
   assign done_rise = sa_done & ~sa_done_q;

   // Next-state and datapath control.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      kt_d        = kt_q;
      base_d      = base_q;
      fetch_cnt_d = fetch_cnt_q;
      row_d       = row_q;
      err_d       = err_q;
      ab_d        = ab_q;
      c_d         = c_q;
      acc_load    = 1'b0;
      acc_add     = 1'b0;
`ifdef SA_WATCHDOG_EN
      wdog_d      = wdog_q;
`endif
      case (state_q)
         StIdle: begin
            if (start) begin
               kt_d        = k_tiles;
               base_d      = base_addr;
               k_d         = '0;
               fetch_cnt_d = '0;
               row_d       = '0;
               if (k_tiles != '0) begin
                  err_d   = 1'b0;
                  state_d = StFetch;
               end else begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end
            end
         end
         StFetch: begin
            if (fetch_cnt_q != 4'd0) begin
               ab_d[wr_idx] = rd_data;
            end
            if (fetch_cnt_q == 4'd8) begin
               state_d = StKick;
            end else begin
               fetch_cnt_d = fetch_cnt_q + 4'd1;
            end
         end
         StKick: begin
            state_d = StWait;
`ifdef SA_WATCHDOG_EN
            wdog_d  = '0;
`endif
         end
         StWait: begin
            if (done_rise) begin
               c_d     = {sa_c3, sa_c2, sa_c1, sa_c0};
               state_d = StAccum;
`ifdef SA_WATCHDOG_EN
            end else if (wdog_q == WdW'(WDOG_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               wdog_d  = wdog_q + 1'b1;
`endif
            end
         end
         StAccum: begin
            acc_load = (k_q == '0);
            acc_add  = (k_q != '0);
            if ((k_q + KT_BITS'(1)) == kt_q) begin
               row_d   = '0;
               state_d = StDrain;
            end else begin
               k_d         = k_q + KT_BITS'(1);
               fetch_cnt_d = '0;
               state_d     = StFetch;
            end
         end
         StDrain: begin
            if (out_ready) begin
               if (row_q == 2'd3) begin
                  state_d = StDone;
               end else begin
                  row_d = row_q + 2'd1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         k_q         <= '0;
         kt_q        <= '0;
         base_q      <= '0;
         fetch_cnt_q <= '0;
         row_q       <= '0;
         err_q       <= 1'b0;
         sa_done_q   <= 1'b0;
         ab_q        <= '0;
         c_q         <= '0;
`ifdef SA_WATCHDOG_EN
         wdog_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         kt_q        <= kt_d;
         base_q      <= base_d;
         fetch_cnt_q <= fetch_cnt_d;
         row_q       <= row_d;
         err_q       <= err_d;
         sa_done_q   <= sa_done;
         ab_q        <= ab_d;
         c_q         <= c_d;
`ifdef SA_WATCHDOG_EN
         wdog_q      <= wdog_d;
`endif
      end
   end

   sa_acc_bank u_acc (
      .clk_i     (clk),
      .rst_i     (rst),
      .load_i    (acc_load),
      .add_i     (acc_add),
      .c_i       (c_q),
      .rd_row_i  (row_q),
      .rd_data_o (acc_rd)
   );

   assign rd_en     = (state_q == StFetch) && !fetch_cnt_q[3];
   assign rd_addr   = rd_en ? (base_q + ADDR_BITS'({k_q, 3'b000}) + ADDR_BITS'(fetch_cnt_q)) : '0;
   assign sa_rst_n  = (state_q != StKick);
   assign sa_busy   = (state_q == StKick) || (state_q == StWait);
   assign out_valid = (state_q == StDrain);
   assign out_row   = out_valid ? row_q : 2'd0;
   assign out_data  = out_valid ? acc_rd : '0;
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);
   assign err       = err_q;

   assign sa_a0 = ab_q[0];
   assign sa_a1 = ab_q[1];
   assign sa_a2 = ab_q[2];
   assign sa_a3 = ab_q[3];
   assign sa_b0 = ab_q[4];
   assign sa_b1 = ab_q[5];
   assign sa_b2 = ab_q[6];
   assign sa_b3 = ab_q[7];

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Self-checking bench for sa_tile_sequencer: tile memory, core and sink models plus a matmul reference.
module tb_sa_tile_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst, start, rd_en, sa_rst_n, sa_busy, sa_done, out_valid, out_ready;
   logic               busy, done, err;
   logic [3:0]         k_tiles;
   logic [15:0]        base_addr, rd_addr;
   logic [31:0]        rd_data;
   logic [3:0][31:0]   sa_a, sa_b;
   logic [3:0][127:0]  sa_c;
   logic [1:0]         out_row;
   logic [127:0]       out_data;

   sa_tile_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .k_tiles(k_tiles), .base_addr(base_addr),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .sa_rst_n(sa_rst_n), .sa_busy(sa_busy), .sa_done(sa_done),
      .sa_a0(sa_a[0]), .sa_a1(sa_a[1]), .sa_a2(sa_a[2]), .sa_a3(sa_a[3]),
      .sa_b0(sa_b[0]), .sa_b1(sa_b[1]), .sa_b2(sa_b[2]), .sa_b3(sa_b[3]),
      .sa_c0(sa_c[0]), .sa_c1(sa_c[1]), .sa_c2(sa_c[2]), .sa_c3(sa_c[3]),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_data(out_data),
      .busy(busy), .done(done), .err(err)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] mem [256];

   // ---------------- helpers / reference model ----------------
   function automatic int lane8(input logic [31:0] w, input int j);
      logic [7:0] b;
      b = w[31-8*j -: 8];
      return int'($signed(b));
   endfunction

   // One tile product, used by the core model.
   function automatic logic [127:0] prod_row(input logic [3:0][31:0] a, input logic [3:0][31:0] b,
                                             input int r);
      logic [127:0] res;
      for (int j = 0; j < 4; j++) begin
         int s = 0;
         for (int m = 0; m < 4; m++) s += lane8(a[r], m) * lane8(b[m], j);
         res[127-32*j -: 32] = s;
      end
      return res;
   endfunction

   // Expected C row: sum over K-tiles straight from the tile memory.
   function automatic logic [127:0] model_row(input int base, input int k, input int r);
      logic [127:0] res;
      for (int j = 0; j < 4; j++) begin
         int s = 0;
         for (int t = 0; t < k; t++)
            for (int m = 0; m < 4; m++)
               s += lane8(mem[base + 8*t + r], m) * lane8(mem[base + 8*t + 4 + m], j);
         res[127-32*j -: 32] = s;
      end
      return res;
   endfunction

   task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- tile memory: data one cycle after rd_en ----------------
   logic        pend_en;
   logic [15:0] pend_addr;
   always @(negedge clk) begin
      pend_en   <= rd_en;
      pend_addr <= rd_addr;
   end
   always @(posedge clk) rd_data <= pend_en ? mem[pend_addr[7:0]] : $urandom;

   // ---------------- core model ----------------
   int  core_lat = 4;
   bit  core_dead = 1'b0;
   int  ccnt = 0, hold = 0;
   logic [3:0][127:0] core_res;
   always @(negedge clk) begin
      if (rst) begin
         ccnt = 0; hold = 0; sa_done = 1'b0;
      end else if (!sa_rst_n) begin
         sa_done = 1'b0;
         ccnt = core_lat;
         for (int r = 0; r < 4; r++) core_res[r] = prod_row(sa_a, sa_b, r);
      end else if (ccnt > 0) begin
         ccnt--;
         if (ccnt == 0 && !core_dead) begin
            sa_done = 1'b1; sa_c = core_res; hold = 3;
         end
      end else if (hold > 0) begin
         hold--;
         if (hold == 0) begin
            sa_done = 1'b0;
            for (int r = 0; r < 4; r++) sa_c[r] = {$urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   // ---------------- monitor ----------------
   int rd_cnt = 0, kick_cnt = 0, done_cnt = 0, done_cyc = 0, beat_cyc = 0, wait_cyc = 0;
   int valid_cnt = 0;
   bit prev_wait = 1'b0;
   logic [129:0] beats[$];
   logic [129:0] stalls[$];
   logic [15:0]  addrs[$];
   always @(negedge clk) begin
      if (!rst) begin
         if (rd_en) begin rd_cnt <= rd_cnt + 1; addrs.push_back(rd_addr); end
         if (!sa_rst_n) kick_cnt <= kick_cnt + 1;
         if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
         if (out_valid) valid_cnt <= valid_cnt + 1;
         if (out_valid && out_ready) begin beats.push_back({out_row, out_data}); beat_cyc <= cyc; end
         if (out_valid && !out_ready) stalls.push_back({out_row, out_data});
         if (sa_busy && sa_rst_n && !prev_wait) wait_cyc <= cyc;
         prev_wait <= sa_busy && sa_rst_n;
      end
   end

   // ---------------- sink: optional stall on one beat ----------------
   int stall_row = -1;
   int stall_left = 0;
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (out_valid && int'(out_row) == stall_row && stall_left > 0) begin
            out_ready = 1'b0; stall_left--;
         end else out_ready = 1'b1;
      end
   end

   // ---------------- job driver ----------------
   int s_rd, s_kick, s_done, s_beat, s_stall, s_addr, s_valid;
   task automatic snap();
      s_rd = rd_cnt; s_kick = kick_cnt; s_done = done_cnt; s_beat = beats.size();
      s_stall = stalls.size(); s_addr = addrs.size(); s_valid = valid_cnt;
   endtask

   task automatic run_job(input int k, input int base, input bit poke);
      int n;
      snap();
      @(posedge clk); #1; start = 1'b1; k_tiles = k[3:0]; base_addr = base[15:0];
      @(posedge clk); #1; start = 1'b0;
      if (poke) begin
         repeat (4) @(posedge clk);
         #1; start = 1'b1; k_tiles = 4'd0; base_addr = 16'hFFFF;
         @(posedge clk); #1; start = 1'b0;
      end
      n = 0;
      while (done_cnt == s_done && n < 3000) begin @(posedge clk); n++; end
      chk("job_finished", {129'd0, done_cnt != s_done}, 130'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_rows(input string tag, input int k, input int base);
      chk({tag, "_beats"}, 130'(beats.size() - s_beat), 130'd4);
      for (int r = 0; r < 4 && s_beat + r < beats.size(); r++)
         chk($sformatf("%s_row%0d", tag, r), beats[s_beat + r], {r[1:0], model_row(base, k, r)});
      chk({tag, "_done_once"}, 130'(done_cnt - s_done), 130'd1);
      chk({tag, "_done_after_beat3"}, 130'(done_cyc - beat_cyc), 130'd1);
      chk({tag, "_err"}, {129'd0, err}, 130'd0);
      chk({tag, "_kicks"}, 130'(kick_cnt - s_kick), 130'(k));
      chk({tag, "_reads"}, 130'(rd_cnt - s_rd), 130'(8 * k));
   endtask

   task automatic load_identity(input int base);
      mem[base + 0] = 32'h01000000; mem[base + 1] = 32'h00010000;
      mem[base + 2] = 32'h00000100; mem[base + 3] = 32'h00000001;
      mem[base + 4] = 32'h01020304; mem[base + 5] = 32'h05060708;
      mem[base + 6] = 32'h090A0B0C; mem[base + 7] = 32'h0D0E0F10;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int k, base, n;
      rst = 1'b1; start = 1'b0; k_tiles = '0; base_addr = '0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {129'd0, busy}, 130'd0);
      chk("rst_sa_rst_n", {129'd0, sa_rst_n}, 130'd1);
      chk("rst_outs", {126'd0, rd_en, out_valid, done, err}, 130'd0);
      chk("rst_out_data", {2'd0, out_data}, 130'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // identity A times known B, one tile
      load_identity(16);
      run_job(1, 16, 1'b0);
      check_rows("ident", 1, 16);
      chk("ident_row0_const", beats[s_beat], {2'd0, 32'd1, 32'd2, 32'd3, 32'd4});
      chk("ident_row3_const", beats[s_beat + 3], {2'd3, 32'd13, 32'd14, 32'd15, 32'd16});

      // same tile twice: every lane doubled, 16 consecutive reads
      load_identity(64); load_identity(72);
      run_job(2, 64, 1'b0);
      check_rows("twice", 2, 64);
      chk("twice_row0_const", beats[s_beat], {2'd0, 32'd2, 32'd4, 32'd6, 32'd8});
      for (int i = 0; i < 16; i++)
         chk($sformatf("twice_addr%0d", i), 130'(addrs[s_addr + i]), 130'(64 + i));

      // random tiles, stall on beat 1, stray start while busy
      k = $urandom_range(2, 3); base = $urandom_range(0, 150); core_lat = $urandom_range(2, 9);
      stall_row = 1; stall_left = 5;
      run_job(k, base, 1'b1);
      check_rows("rand_stall", k, base);
      chk("stall_cycles", 130'(stalls.size() - s_stall), 130'd5);
      for (int i = s_stall; i < stalls.size(); i++)
         chk("stall_hold", stalls[i], {2'd1, model_row(base, k, 1)});
      for (int i = 0; i < 8 * k; i++)
         chk($sformatf("rand_addr%0d", i), 130'(addrs[s_addr + i]), 130'(base + i));
      stall_row = -1;

      // k_tiles == 0: error, done pulse, nothing else
      run_job(0, 32, 1'b0);
      chk("k0_err", {129'd0, err}, 130'd1);
      chk("k0_reads", 130'(rd_cnt - s_rd), 130'd0);
      chk("k0_kicks", 130'(kick_cnt - s_kick), 130'd0);
      chk("k0_valid", 130'(valid_cnt - s_valid), 130'd0);
      chk("k0_done_once", 130'(done_cnt - s_done), 130'd1);

      // err clears on the next accepted start
      k = 1; base = $urandom_range(0, 150);
      run_job(k, base, 1'b0);
      check_rows("after_k0", k, base);

      // reset in the middle of WAIT
      core_lat = 40; base = $urandom_range(0, 150);
      snap();
      @(posedge clk); #1; start = 1'b1; k_tiles = 4'd1; base_addr = base[15:0];
      @(posedge clk); #1; start = 1'b0;
      n = 0;
      while (!(sa_busy && sa_rst_n) && n < 100) begin @(posedge clk); #1; n++; end
      chk("reached_wait", {129'd0, sa_busy && sa_rst_n}, 130'd1);
      repeat (3) @(posedge clk);
      #1; rst = 1'b1; #1;
      chk("mid_rst_state", {124'd0, busy, sa_busy, rd_en, out_valid, done, err}, 130'd0);
      chk("mid_rst_sa_rst_n", {129'd0, sa_rst_n}, 130'd1);
      chk("mid_rst_sa_a0", 130'(sa_a[0]), 130'd0);
      @(posedge clk); #1; rst = 1'b0;
      repeat (2) @(posedge clk);
      chk("mid_rst_no_done", 130'(done_cnt - s_done), 130'd0);
      core_lat = $urandom_range(2, 9); base = $urandom_range(0, 150);
      run_job(1, base, 1'b0);
      check_rows("post_rst", 1, base);

`ifdef SA_WATCHDOG_EN
      // core never finishes: watchdog ends the job
      core_dead = 1'b1;
      run_job(1, 8, 1'b0);
      chk("wdog_err", {129'd0, err}, 130'd1);
      chk("wdog_delay", 130'(done_cyc - wait_cyc), 130'd64);
      chk("wdog_no_valid", 130'(valid_cnt - s_valid), 130'd0);
      core_dead = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case a wait above is somehow never reached.
   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/sa_tile_sequencer.md
Name: sa_tile_sequencer

Overview:
Controller that drives one 4x4 int8 systolic-array core through a K-tiled matrix multiply. Per K-tile it does four things in order:
- fetches one A tile and one B tile (4 packed 32-bit rows each) from the tile buffer;
- restarts the array;
- waits for its done flag and captures the 4x128-bit result;
- accumulates the result into a 4x4 array of 32-bit partial sums.
After the last K-tile it streams the four accumulated C rows out over a valid/ready port and pulses done. It sits between the user-project register/buffer logic and the systolic-array core.

Parameters:
ADDR_BITS, 16, tile-buffer read address width
DATA_BITS, 32, A/B row width (4 x int8)
DATAC_BITS, 128, C row width (4 x 32-bit)
KT_BITS, 4, width of the K-tile count
WDOG_CYCLES, 64, cycles allowed in WAIT (used only with the optional feature)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle start pulse; ignored unless IDLE
k_tiles  in  KT_BITS  number of K-tiles; sampled on start
base_addr  in  ADDR_BITS  tile-buffer base; sampled on start
rd_en  out  1  tile-buffer read strobe
rd_addr  out  ADDR_BITS  read address
rd_data  in  DATA_BITS  read data, valid exactly 1 cycle after rd_en
sa_rst_n  out  1  active-low restart to the array core
sa_busy  out  1  high from KICK through WAIT
sa_done  in  1  array done flag (level; may stay high >1 cycle)
sa_a0..sa_a3  out  DATA_BITS each  A rows to the core
sa_b0..sa_b3  out  DATA_BITS each  B rows to the core
sa_c0..sa_c3  in  DATAC_BITS each  C rows from the core; valid when sa_done rises
out_valid  out  1  result beat valid
out_ready  in  1  downstream accept
out_row  out  2  row index of the current beat
out_data  out  DATAC_BITS  accumulated C row {c[r][0],c[r][1],c[r][2],c[r][3]}, c[r][0] in [127:96]
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  sticky error; cleared on the next accepted start

Behaviour:
- Reset (async): state IDLE, all outputs 0 except sa_rst_n=1, accumulators 0, k index 0. Reset in any state aborts the job; no done pulse is issued.
- States: IDLE, FETCH, KICK, WAIT, ACCUM, DRAIN, DONE.
- IDLE:
  - start with k_tiles != 0 -> FETCH, err=0, k=0.
  - start with k_tiles == 0 -> DONE, err=1, no output beats.
- FETCH:
  - 8 consecutive rd_en cycles at rd_addr = base + 8*k + i, i = 0..7; i=0..3 are A rows, 4..7 are B rows.
  - Data is registered into the sa_a/sa_b holding registers one cycle after each rd_en.
  - Goes to KICK the cycle after the last datum lands (9 cycles total).
- KICK: sa_rst_n=0 for exactly one cycle; sa_busy=1. sa_a*/sa_b* stay stable from KICK until leaving WAIT -> WAIT.
- WAIT:
  - Rising edge of sa_done (registered edge detect) -> capture sa_c0..3 that cycle -> ACCUM.
  - Later sa_done levels and any free-running rerun of the core are ignored.
- ACCUM (1 cycle):
  - k==0: acc[r][j] = c[r][j]; otherwise acc[r][j] += c[r][j], 32-bit two's-complement wrap, no saturation.
  - Then k+1 == k_tiles -> DRAIN; else k++ -> FETCH.
- DRAIN:
  - Beats r = 0..3 in order, out_valid=1.
  - out_data/out_row held stable while out_valid && !out_ready.
  - Beat retires on out_valid && out_ready; after beat 3 -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- start while busy: ignored, no effect on the current job.
- Latency per K-tile: 9 (FETCH) + 1 (KICK) + core time + 1 (edge detect/capture) + 1 (ACCUM).

Optional Feature:
SA_WATCHDOG_EN
- Defined: a WAIT-cycle counter resets on entering WAIT. If it reaches WDOG_CYCLES without a sa_done rise: err=1, accumulators unchanged, no output beats, -> DONE (done still pulses).
- Undefined: no counter; WAIT is unbounded; err is set only by k_tiles==0.

Decomposition:
- Package sa_pkg: state enum encoding; ROWS=4, LANES=4, LANE_BITS=32 constants; row pack/unpack helper.
- One natural sub-module, sa_acc_bank: 16 x 32-bit accumulators with load/add control and a row-select read port for DRAIN.

Test Plan:
- A = identity (rows 01000000,00010000,00000100,00000001 hex), B rows 01020304, 05060708, 090A0B0C, 0D0E0F10, k_tiles=1 -> out rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}; done one cycle after beat 3.
- Same tiles stored twice, k_tiles=2 -> every lane doubled (row0 {2,4,6,8}); 16 rd_en pulses at base..base+15; sa_rst_n low exactly twice.
- out_ready held low 5 cycles on beat 1 -> out_data/out_row=1 stable throughout; 4 beats total; no duplicate beats.
- k_tiles=0 -> no rd_en, no sa_rst_n pulse, done pulse, err=1; err clears on the next start.
- rst asserted mid-WAIT -> outputs immediately at reset values; subsequent start with k_tiles=1 produces the correct result.
- SA_WATCHDOG_EN with WDOG_CYCLES=64, sa_done tied 0 -> err=1 and done 64 cycles after entering WAIT, out_valid never asserted.
